// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder: state encodings and the
// default timing constants reused by the top-level instantiation.
package button_event_decoder_pkg;

  // 3-bit state encodings; values 6 and 7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS_DB  = 3'd1,
    ST_HELD      = 3'd2,
    ST_GAP       = 3'd3,
    ST_PRESS2_DB = 3'd4,
    ST_WAIT_REL  = 3'd5
  } state_t;

  // Default timing constants.
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_LONG_CYCLES     = 16;
  localparam int DEF_DOUBLE_GAP      = 8;
  localparam int DEF_CNT_W           = 5;

  // Largest terminal count the shared timer must be able to reach.
  function automatic int max_term(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m - 1;
  endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Button-side bundle: the synchronised button level going in, and the
// gesture event pulses plus busy flag coming out.
interface button_event_decoder_if;
  logic btn_sync;
  logic ev_short;
  logic ev_long;
  logic ev_double;
  logic busy;

  // Upstream/downstream side: drives the button, observes the events.
  modport master (
    output btn_sync,
    input  ev_short,
    input  ev_long,
    input  ev_double,
    input  busy
  );

  // Decoder side.
  modport slave (
    input  btn_sync,
    output ev_short,
    output ev_long,
    output ev_double,
    output busy
  );
endinterface

// File: rtl/button_event_decoder_event_timer.sv
// Shared gesture timer: saturating up-counter with synchronous clear and a
// terminal-count compare against a caller-selected value.
module button_event_decoder_event_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_term,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_hit
);

  logic [CNT_W-1:0] r_cnt;

  // Count up each cycle, hold at all-ones, restart whenever the FSM moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != {CNT_W{1'b1}}) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_hit = (r_cnt == i_term);

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button gestures as short, long or double press and
// emits one registered single-cycle pulse per gesture.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int DOUBLE_GAP      = DEF_DOUBLE_GAP,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  button_event_decoder_if.slave  bus
);

  // Terminal counts: a state exits when the timer reaches N-1, i.e. on its
  // N-th cycle in that state.
  localparam logic [CNT_W-1:0] DB_TERM   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(DOUBLE_GAP - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ev_short;
  logic             r_ev_long;
  logic             r_ev_double;
  logic             w_ev_short_nxt;
  logic             w_ev_long_nxt;
  logic             w_ev_double_nxt;
  logic             w_clr;
  logic             w_hit;
  logic [CNT_W-1:0] w_term;
  logic [CNT_W-1:0] w_cnt;
  logic             w_btn;

  assign w_btn = bus.btn_sync;

  // Pick the terminal count relevant to the current state.
  always_comb begin
    w_term = '0;
    case (r_state)
      ST_PRESS_DB,
      ST_PRESS2_DB: w_term = DB_TERM;
      ST_HELD:      w_term = LONG_TERM;
      ST_GAP:       w_term = GAP_TERM;
      default:      w_term = '0;
    endcase
  end

  // Timer restarts on every state change, so each state measures its own dwell.
  assign w_clr = (w_state_nxt != r_state);

  button_event_decoder_event_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_term (w_term),
    .o_cnt  (w_cnt),
    .o_hit  (w_hit)
  );

  // Next-state and event decode; a released button always takes priority
  // over a threshold hit in the same cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_ev_short_nxt  = 1'b0;
    w_ev_long_nxt   = 1'b0;
    w_ev_double_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_btn) w_state_nxt = ST_PRESS_DB;
      end
      ST_PRESS_DB: begin
        if (!w_btn)     w_state_nxt = ST_IDLE;
        else if (w_hit) w_state_nxt = ST_HELD;
      end
      ST_HELD: begin
        if (!w_btn) begin
          w_state_nxt = ST_GAP;
        end else if (w_hit) begin
          w_state_nxt   = ST_WAIT_REL;
          w_ev_long_nxt = 1'b1;
        end
      end
      ST_GAP: begin
        if (w_btn) begin
          w_state_nxt = ST_PRESS2_DB;
        end else if (w_hit) begin
          w_state_nxt    = ST_IDLE;
          w_ev_short_nxt = 1'b1;
        end
      end
      ST_PRESS2_DB: begin
        // A bounce back to low re-enters GAP with a fresh window.
        if (!w_btn) begin
          w_state_nxt = ST_GAP;
        end else if (w_hit) begin
          w_state_nxt     = ST_WAIT_REL;
          w_ev_double_nxt = 1'b1;
        end
      end
      ST_WAIT_REL: begin
        if (!w_btn) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and registered event pulses, updated on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ev_short  <= 1'b0;
      r_ev_long   <= 1'b0;
      r_ev_double <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ev_short  <= w_ev_short_nxt;
      r_ev_long   <= w_ev_long_nxt;
      r_ev_double <= w_ev_double_nxt;
    end
  end

  assign bus.ev_short  = r_ev_short;
  assign bus.ev_long   = r_ev_long;
  assign bus.ev_double = r_ev_double;
  assign bus.busy      = (r_state != ST_IDLE);

  // The raw count is only needed inside the timer compare.
  logic w_unused;
  assign w_unused = ^w_cnt;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder at default timing. Button driven on
// the falling edge, outputs sampled 1 ns after each rising edge.
module tb_button_event_decoder;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   n     = 0;      // index of the most recent rising edge
  int   n0;
  int   n_short, n_long, n_double;
  int   at_short, at_long, at_double;

  button_event_decoder_if bif ();

  button_event_decoder #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (16),
    .DOUBLE_GAP      (8),
    .CNT_W           (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr_ev();
    n_short = 0; n_long = 0; n_double = 0;
    at_short = -1; at_long = -1; at_double = -1;
  endtask

  // One clock: drive btn on negedge, sample outputs just after posedge.
  task automatic cyc(input logic b);
    @(negedge clk);
    bif.btn_sync = b;
    @(posedge clk);
    #1;
    n++;
    if (bif.ev_short  === 1'b1) begin n_short++;  at_short  = n; end
    if (bif.ev_long   === 1'b1) begin n_long++;   at_long   = n; end
    if (bif.ev_double === 1'b1) begin n_double++; at_double = n; end
  endtask

  task automatic hold(input logic b, input int k);
    for (int i = 0; i < k; i++) cyc(b);
  endtask

  initial begin
    rst_n = 1'b0;
    bif.btn_sync = 1'b0;
    clr_ev();
    hold(1'b0, 3);
    chk("rst_busy", int'(bif.busy), 0);
    chk("rst_short", int'(bif.ev_short), 0);
    chk("rst_long", int'(bif.ev_long), 0);
    chk("rst_double", int'(bif.ev_double), 0);
    rst_n = 1'b1;
    hold(1'b0, 2);
    chk("idle_busy", int'(bif.busy), 0);

    // 1: three-cycle glitch is rejected
    clr_ev();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      chk("t1_busy_hi", int'(bif.busy), 1);
    end
    cyc(1'b0);
    chk("t1_busy_lo", int'(bif.busy), 0);
    hold(1'b0, 12);
    chk("t1_events", n_short + n_long + n_double, 0);

    // 2: short press, event 8 clocks after release sampled
    clr_ev();
    n0 = n + 1;
    hold(1'b1, 6);
    hold(1'b0, 12);
    chk("t2_nshort", n_short, 1);
    chk("t2_at", at_short, n0 + 14);
    chk("t2_other", n_long + n_double, 0);

    // 3: long press, event 20 clocks after first high sample
    clr_ev();
    n0 = n + 1;
    hold(1'b1, 30);
    chk("t3_nlong", n_long, 1);
    chk("t3_at", at_long, n0 + 20);
    chk("t3_other", n_short + n_double, 0);
    chk("t3_busy_held", int'(bif.busy), 1);
    cyc(1'b0);
    chk("t3_busy_rel", int'(bif.busy), 0);
    hold(1'b0, 12);
    chk("t3_after", n_long + n_short + n_double, 1);

    // 4: double press
    clr_ev();
    n0 = n + 1;
    hold(1'b1, 6);
    hold(1'b0, 3);
    hold(1'b1, 6);
    hold(1'b0, 12);
    chk("t4_ndouble", n_double, 1);
    chk("t4_at", at_double, n0 + 13);
    chk("t4_other", n_short + n_long, 0);

    // 5: bounce during second press restarts gap window
    clr_ev();
    n0 = n + 1;
    hold(1'b1, 6);
    hold(1'b0, 3);
    hold(1'b1, 2);
    hold(1'b0, 10);
    chk("t5_nshort", n_short, 1);
    chk("t5_at", at_short, n0 + 19);
    chk("t5_other", n_long + n_double, 0);

    // Boundary: release on the exact long-threshold edge -> short, not long
    clr_ev();
    n0 = n + 1;
    hold(1'b1, 20);
    hold(1'b0, 10);
    chk("tb_nlong", n_long, 0);
    chk("tb_nshort", n_short, 1);
    chk("tb_at", at_short, n0 + 28);

    // 6: asynchronous reset mid-HELD
    clr_ev();
    hold(1'b1, 10);
    chk("t6_busy_pre", int'(bif.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_busy_rst", int'(bif.busy), 0);
    chk("t6_ev_rst", int'(bif.ev_short) + int'(bif.ev_long) + int'(bif.ev_double), 0);
    hold(1'b1, 2);
    chk("t6_busy_inrst", int'(bif.busy), 0);
    rst_n = 1'b1;
    hold(1'b1, 10);
    chk("t6_no_ev_held", n_short + n_long + n_double, 0);
    hold(1'b0, 12);
    chk("t6_no_long", n_long + n_double, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
